// File: rtl/uart_replay_buf.sv
// Store-and-replay buffer between the UART receiver and transmitter.
// Characters received while idle are stored; a start press replays them rep times.
module uart_replay_buf #(
  parameter int DW   = 8,
  parameter int AW   = 10,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_vld,
  input  logic [DW-1:0] rx_data,
  input  logic          txrdy,
  input  logic          start,
  input  logic          clear,
  input  logic [3:0]    rep,
  output logic          tx_vld,
  output logic [DW-1:0] tx_data,
  output logic          busy,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          dropped
);

  // state | meaning
  // IDLE  | accepting characters, waiting for start
  // RD    | synchronous RAM read into tx_data
  // SEND  | waiting for txrdy, then strobe tx_vld
  // WLO   | waiting for transmitter to accept (txrdy low)
  // WHI   | waiting for transmitter to finish (txrdy high)
  typedef enum logic [2:0] {IDLE, RD, SEND, WLO, WHI} state_t;

  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  state_t          state_q, state_d;
  logic [DW-1:0]   mem [0:(1<<AW)-1];
  logic [SYNC-1:0] sync_q;
  logic            prev_q;
  logic            st_edge;
  logic [AW-1:0]   rd_ptr;
  logic [3:0]      passes;
  logic            abort_pend;
  logic            more;
  logic            wr_en;

  assign st_edge = sync_q[SYNC-1] & ~prev_q;
  assign more    = ({1'b0, rd_ptr} + {{AW{1'b0}}, 1'b1}) < count;
  assign wr_en   = rx_vld & (state_q == IDLE) & (count != FULL) & ~clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], start};
      prev_q <= sync_q[SYNC-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (st_edge && count != '0) state_d = RD;
      RD:   state_d = SEND;
      SEND: if (txrdy) state_d = WLO;
      WLO:  if (!txrdy) state_d = WHI;
      WHI:  if (txrdy) state_d = (abort_pend || (!more && passes <= 4'd1)) ? IDLE : RD;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_comb begin
    tx_vld = (state_q == SEND) && txrdy && !clear;
    busy   = (state_q != IDLE);
  end

  // RAM kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      overflow   <= 1'b0;
      dropped    <= 1'b0;
      abort_pend <= 1'b0;
      passes     <= '0;
      rd_ptr     <= '0;
      tx_data    <= '0;
    end else if (clear) begin
      count      <= '0;
      overflow   <= 1'b0;
      dropped    <= 1'b0;
      abort_pend <= 1'b0;
      passes     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (rx_vld) begin
        if (state_q != IDLE) dropped <= 1'b1;
        else if (count == FULL) overflow <= 1'b1;
        else count <= count + 1'b1;
      end
      case (state_q)
        IDLE: if (st_edge && count != '0) begin
          passes <= (rep == 4'd0) ? 4'd1 : rep;
          rd_ptr <= '0;
        end
        RD: tx_data <= mem[rd_ptr];
        WHI: if (txrdy && !abort_pend) begin
          if (more) rd_ptr <= rd_ptr + 1'b1;
          else if (passes > 4'd1) begin
            passes <= passes - 4'd1;
            rd_ptr <= '0;
          end
        end
        default: ;
      endcase
      // A press during replay aborts at the next character boundary; the pending
      // request is dropped whenever the block lands back in IDLE.
      if (st_edge && state_q != IDLE) abort_pend <= 1'b1;
      if (state_d == IDLE) abort_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_replay_buf.sv
// Self-checking bench for uart_replay_buf: table-driven replay vectors,
// hand-written abort/clear/reset sequences, and randomized runs against a queue model.
module tb_uart_replay_buf;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 0, rst = 1;
  logic          rx_vld = 0, txrdy = 1, start = 0, clear = 0;
  logic [DW-1:0] rx_data = '0;
  logic [3:0]    rep = '0;
  logic          tx_vld, busy, overflow, dropped;
  logic [DW-1:0] tx_data;
  logic [AW:0]   count;

  uart_replay_buf #(.DW(DW), .AW(AW), .SYNC(2)) dut (
    .clk(clk), .rst(rst), .rx_vld(rx_vld), .rx_data(rx_data), .txrdy(txrdy),
    .start(start), .clear(clear), .rep(rep), .tx_vld(tx_vld), .tx_data(tx_data),
    .busy(busy), .count(count), .overflow(overflow), .dropped(dropped));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  logic [7:0] got[$];
  int stamps[$];
  bit auto_tx = 1;
  int lo_len = 2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transmitter model: on each accepted character, drop txrdy for lo_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_vld === 1'b1) begin
        got.push_back(tx_data);
        stamps.push_back(cyc);
        if (auto_tx) begin
          @(negedge clk);
          txrdy = 0;
          repeat (lo_len) @(negedge clk);
          txrdy = 1;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1;
    @(negedge clk);
    rx_vld  = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    @(negedge clk);
    clear = 0;
  endtask

  task automatic press(output int c0);
    c0 = cyc;
    start = 1;
    repeat (2) @(negedge clk);
    start = 0;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (busy && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  typedef struct {
    int   n;
    logic [3:0] rp;
    int   lo;
    bit   inj;
    int   exp_count;
    bit   exp_ovf;
    bit   exp_drop;
    int   exp_pulses;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int c0, mn, mx, k;
    logic [7:0] model[$];
    logic [7:0] exp_q[$];

    vecs[0] = '{3, 4'd0,  2, 1'b0, 3, 1'b0, 1'b0, 3};
    vecs[1] = '{3, 4'd3,  2, 1'b0, 3, 1'b0, 1'b0, 9};
    vecs[2] = '{5, 4'd1,  1, 1'b1, 4, 1'b1, 1'b1, 4};
    vecs[3] = '{1, 4'd15, 3, 1'b0, 1, 1'b0, 1'b0, 15};
    vecs[4] = '{4, 4'd0,  2, 1'b1, 4, 1'b0, 1'b1, 4};
    vecs[5] = '{4, 4'd2,  4, 1'b0, 4, 1'b0, 1'b0, 8};

    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({tx_vld, tx_data, busy, count, overflow, dropped}), 32'd0);
    rst = 0;
    repeat (2) @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      do_clear();
      got.delete(); stamps.delete();
      lo_len = vecs[r].lo;
      for (int i = 0; i < vecs[r].n; i++) send_byte(8'(8'h41 + i));
      chk("count_rx", 32'(count), 32'(vecs[r].exp_count));
      chk("overflow", 32'(overflow), 32'(vecs[r].exp_ovf));
      rep = vecs[r].rp;
      press(c0);
      @(negedge clk);
      if (vecs[r].inj) send_byte(8'hEE);
      wait_idle(2000);
      chk("pulses", 32'(got.size()), 32'(vecs[r].exp_pulses));
      for (int i = 0; i < got.size() && i < vecs[r].exp_pulses; i++)
        chk("tx_data", 32'(got[i]), 32'(8'h41 + (i % vecs[r].exp_count)));
      chk("dropped", 32'(dropped), 32'(vecs[r].exp_drop));
      chk("count_after", 32'(count), 32'(vecs[r].exp_count));
      if (r == 0 && stamps.size() > 0) chk("start_latency", 32'(stamps[0] - c0), 32'd4);
      if (stamps.size() > 1) begin
        mn = 1 << 30; mx = 0;
        for (int i = 1; i < stamps.size(); i++) begin
          k = stamps[i] - stamps[i-1];
          if (k < mn) mn = k;
          if (k > mx) mx = k;
        end
        chk("gap_max", 32'(mx), 32'(vecs[r].lo + 3));
        chk("gap_min", 32'(mn), 32'(vecs[r].lo + 3));
      end
    end

    // Abort: second press after the first character stops replay after it.
    do_clear();
    got.delete(); stamps.delete();
    lo_len = 4;
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
    rep = 4'd2;
    press(c0);
    k = 0;
    while (got.size() == 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    press(c0);
    wait_idle(200);
    chk("abort_pulses", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("abort_data", 32'(got[0]), 32'h41);
    chk("abort_count", 32'(count), 32'd3);

    // Clear while SEND with txrdy rising, also racing a write.
    repeat (8) @(negedge clk);
    auto_tx = 0;
    txrdy = 0;
    do_clear();
    got.delete(); stamps.delete();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i));
    press(c0);
    @(negedge clk);
    send_byte(8'hEE);
    chk("pre_clear_flags", 32'({overflow, dropped, busy}), 32'b111);
    txrdy = 1;
    clear = 1;
    rx_vld = 1;
    #1;
    chk("clear_no_txvld", 32'(tx_vld), 32'd0);
    @(negedge clk);
    clear = 0;
    rx_vld = 0;
    chk("clear_state", 32'({count, overflow, dropped, busy}), 32'd0);
    press(c0);
    repeat (6) @(negedge clk);
    chk("empty_start_busy", 32'(busy), 32'd0);
    chk("empty_start_tx", 32'(got.size()), 32'd0);
    auto_tx = 1;

    // Randomized runs against a queue model of the buffer.
    for (int it = 0; it < 10; it++) begin
      int n, inj;
      logic [3:0] rp;
      do_clear();
      got.delete(); stamps.delete(); model.delete(); exp_q.delete();
      n = $urandom_range(0, 6);
      rp = 4'($urandom_range(0, 5));
      lo_len = $urandom_range(1, 4);
      inj = (n > 0) ? $urandom_range(0, 1) : 0;
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (model.size() < DEPTH) model.push_back(b);
        send_byte(b);
      end
      if (model.size() > 0)
        for (int p = 0; p < ((rp == 0) ? 1 : int'(rp)); p++)
          foreach (model[i]) exp_q.push_back(model[i]);
      chk("rnd_count", 32'(count), 32'(model.size()));
      chk("rnd_overflow", 32'(overflow), 32'(n > DEPTH));
      rep = rp;
      press(c0);
      @(negedge clk);
      if (inj != 0) send_byte(8'hEE);
      wait_idle(2000);
      repeat (2) @(negedge clk);
      chk("rnd_pulses", 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
        chk("rnd_data", 32'(got[i]), 32'(exp_q[i]));
      chk("rnd_dropped", 32'(dropped), 32'(inj));
      chk("rnd_count_after", 32'(count), 32'(model.size()));
    end

    // Asynchronous reset in the middle of a replay.
    do_clear();
    got.delete(); stamps.delete();
    lo_len = 3;
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
    rep = 4'd5;
    press(c0);
    k = 0;
    while (got.size() < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1;
    #1;
    chk("reset_midreplay", 32'({tx_vld, tx_data, busy, count, overflow, dropped}), 32'd0);
    @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);
    chk("reset_stays_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_replay_buf.md
# uart_replay_buf

Parametrised store-and-replay buffer between the UART receiver/transmitter pair (`rxtx`) in the UART loopback design. Every byte received while idle is stored in an internal RAM. A synchronised rising edge on the `start` button replays the whole stored sequence to the transmitter, repeated a programmable number of times. The block also supports abort, clear, and sticky overflow/drop status.

## Interface
Parameters:
- `DW`, 8, data width of one character.
- `AW`, 10, address width; buffer depth is 2^AW entries.
- `SYNC`, 2, number of synchroniser flops on `start` (minimum 2).

Ports:
- `clk`, in, 1, system clock.
- `rst`, in, 1, asynchronous, active-high reset.
- `rx_vld`, in, 1, one-cycle strobe: `rx_data` is valid.
- `rx_data`, in, DW, received character.
- `txrdy`, in, 1, transmitter idle level; falls after accepting a character and rises when the character is done.
- `start`, in, 1, asynchronous button level.
- `clear`, in, 1, synchronous pulse: empty the buffer and abort any replay.
- `rep`, in, 4, replay pass count, latched at start; 0 is treated as 1.
- `tx_vld`, out, 1, one-cycle strobe to the transmitter.
- `tx_data`, out, DW, character; valid while `tx_vld` is high.
- `busy`, out, 1, high while replaying.
- `count`, out, AW+1, number of stored characters (0 to 2^AW).
- `overflow`, out, 1, sticky: a character was dropped because the buffer was full.
- `dropped`, out, 1, sticky: a character was dropped because it arrived during replay.

## Operation
- States: IDLE, RD, SEND, WLO, WHI.
- **Write (IDLE only):** on `rx_vld` with `count` < 2^AW, write `mem[count[AW-1:0]]` and increment `count`.
  - `rx_vld` with `count` == 2^AW sets `overflow`; the character is discarded.
  - `rx_vld` in any non-IDLE state sets `dropped`; the character is discarded and `count` is unchanged.
- **Start detect:** `start` passes through `SYNC` flops plus one edge-detect flop. `st_edge` = sync_out & ~prev.
- **Start in IDLE:** `st_edge` with `count` != 0 latches `passes` = (`rep`==0 ? 1 : `rep`), sets `rd_ptr` = 0, and moves to RD. `st_edge` with `count` == 0 is ignored.
- **RD:** synchronous RAM read of `mem[rd_ptr]`; the result is registered into `tx_data`. Then go to SEND.
- **SEND:** when `txrdy`=1, assert `tx_vld` for exactly one cycle and go to WLO. While `txrdy`=0, hold in SEND with `tx_vld`=0.
- **WLO:** wait for `txrdy`=0, then go to WHI.
- **WHI:** wait for `txrdy`=1, then advance:
  - If `rd_ptr` < `count`-1: increment `rd_ptr` and go to RD.
  - Else if `passes` > 1: decrement `passes`, set `rd_ptr` = 0, and go to RD.
  - Else go to IDLE.
- **Abort:** `st_edge` in any non-IDLE state sets `abort_pend`. At the next WHI exit the block goes to IDLE regardless of `rd_ptr`/`passes`. The character already issued completes normally.
- **Clear:** `clear`=1, in any state, takes priority over everything else. Next cycle: state IDLE, `count`=0, `overflow`=0, `dropped`=0, `abort_pend`=0, `passes`=0, `rd_ptr`=0. `tx_vld` is forced to 0 in the cycle `clear` is high. RAM contents are not cleared.
- **Write/clear same cycle:** `rx_vld` and `clear` in the same cycle leaves the character discarded and `count`=0.
- **`busy`:** equals (state != IDLE).
- **Counters:** `count` is AW+1 bits and saturates at 2^AW, with no wrap. `rd_ptr` is AW bits. `passes` is 4 bits.
- **Memory:** the RAM has no reset and is inferable as block RAM: one write port, one synchronous read port.

## Timing
- **Reset values:** `tx_vld`=0, `tx_data`=0, `busy`=0, `count`=0, `overflow`=0, `dropped`=0, state IDLE, synchroniser and edge flops 0.
- **Start latency:** a `start` rise setup before clk edge k gives `st_edge` high in cycle k+SYNC. `busy` rises at k+SYNC+1 (state RD). The first `tx_vld` occurs at k+SYNC+2 if `txrdy`=1.
- **Write latency:** `count` updates the cycle after `rx_vld`. A character written in cycle n is readable from cycle n+1.
- **Character spacing:** at most 3 cycles of block overhead (RD, SEND, WHI exit) beyond the transmitter's `txrdy` low period.
- **Pass boundaries:** between the last character of one pass and the first of the next there is no extra gap beyond normal spacing.
- **`busy` fall:** `busy` falls the cycle after the final WHI sees `txrdy`=1.
- **Async reset mid-replay:** the block returns to reset values immediately. A partially sent character is the transmitter's concern.

## Test plan
- Receive 0x41, 0x42, 0x43, then pulse `start` with `rep`=0 → `count`=3; exactly 3 `tx_vld` pulses carrying 0x41, 0x42, 0x43; `busy` low afterwards.
- Same 3 bytes with `rep`=3 → 9 `tx_vld` pulses, sequence 41 42 43 repeated 3 times, no extra gap at pass boundaries.
- With AW=2: send 5 bytes → `count`=4, `overflow`=1, bytes 1–4 replayed; send a byte during replay → `dropped`=1, `count` stays 4.
- With `rep`=2 and 3 bytes stored, press `start` again after the first `tx_vld` → only 0x41 is transmitted; IDLE after its WHI; `count` unchanged.
- Pulse `clear` while in SEND with `txrdy`=1 → no `tx_vld` that cycle; next cycle `count`=0, flags 0, `busy`=0; a subsequent `start` is ignored.
- Press `start` with `count`=0 → no state change and no `tx_vld`. Also assert `rst` mid-replay → all outputs return to reset values within the same cycle.
